// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
// Read-side master for a 32-bit FIFO. A start request drains a burst of
// burst_len words: each word is popped with a one-cycle read strobe and
// presented downstream through a registered valid/ready output stage.
//
// Build option: define FIFO_RD_PARITY_EN to add the out_parity output, the
// even parity of each popped word, registered alongside out_data.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic                  abort,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_read,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
`ifdef FIFO_RD_PARITY_EN
    output logic                  out_parity,
`endif
    output logic [LEN_WIDTH-1:0]  words_sent
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  LEN_MAX   = {LEN_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    state_t                  state_r;
    state_t                  next_state_s;
    logic [LEN_WIDTH-1:0]    remaining_r;
    logic [LEN_WIDTH-1:0]    words_sent_r;
    logic [DATA_WIDTH-1:0]   out_data_r;
    logic                    out_valid_r;
    logic                    start_s;
    logic                    abort_s;
    logic                    pop_s;
    logic                    accept_s;
    logic                    fifo_read_s;
    logic                    busy_s;
    logic                    done_s;

`ifdef FIFO_RD_PARITY_EN
    logic                    out_parity_r;

    // Even parity of a FIFO word: 1 when the word holds an odd number of ones.
    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] word);
        calc_parity = ^word;
    endfunction
`endif

    // A start is only honoured from IDLE; abort only matters once a burst is running.
    assign start_s = (state_r == ST_IDLE) && start;
    assign abort_s = (state_r != ST_IDLE) && abort;

    // Pop whenever a word is owed, one is available, and the output register
    // is free or being emptied this very cycle (gives 1 word/clock).
    // Abort suppresses the pop so nothing is lost from the FIFO on that cycle.
    assign pop_s = (state_r == ST_FETCH)
                && !abort
                && !fifo_empty
                && (remaining_r != LEN_ZERO)
                && (!out_valid_r || out_ready);

    // A downstream transfer; a coincident abort wins and discards the word.
    assign accept_s = out_valid_r && out_ready && !abort_s;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    if (burst_len != LEN_ZERO) begin
                        next_state_s = ST_FETCH;
                    end else begin
                        next_state_s = ST_DONE;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (abort_s) begin
                    next_state_s = ST_IDLE;
                end else if (remaining_r == LEN_ZERO) begin
                    next_state_s = ST_FLUSH;
                end else if (pop_s && (remaining_r == LEN_ONE)) begin
                    next_state_s = ST_FLUSH;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_FLUSH: begin
                if (abort_s) begin
                    next_state_s = ST_IDLE;
                end else if (!out_valid_r || out_ready) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_FLUSH;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State-decoded outputs; the read strobe is the pop itself while fetching.
    always_comb begin
        fifo_read_s = 1'b0;
        busy_s      = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                fifo_read_s = 1'b0;
            end
            ST_FETCH: begin
                fifo_read_s = pop_s;
                busy_s      = 1'b1;
            end
            ST_FLUSH: begin
                busy_s      = 1'b1;
            end
            ST_DONE: begin
                done_s      = 1'b1;
            end
            default: begin
                fifo_read_s = 1'b0;
            end
        endcase
    end

    // Output register: load on pop, clear on transfer, hold while stalled.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_data_r  <= DATA_ZERO;
            out_valid_r <= 1'b0;
        end else if (abort_s) begin
            out_valid_r <= 1'b0;
        end else if (pop_s) begin
            out_data_r  <= fifo_data;
            out_valid_r <= 1'b1;
        end else if (accept_s) begin
            out_valid_r <= 1'b0;
        end
    end

`ifdef FIFO_RD_PARITY_EN
    // Parity of the held word, loaded with the same strobe as out_data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_parity_r <= 1'b0;
        end else if (!abort_s && pop_s) begin
            out_parity_r <= calc_parity(fifo_data);
        end
    end
`endif

    // Words still to be popped for the current burst.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            remaining_r <= LEN_ZERO;
        end else if (start_s) begin
            remaining_r <= burst_len;
        end else if (abort_s) begin
            remaining_r <= LEN_ZERO;
        end else if (pop_s) begin
            remaining_r <= remaining_r - LEN_ONE;
        end
    end

    // Count of words accepted downstream; cleared by a new burst, kept across
    // abort, and saturating so it never wraps.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            words_sent_r <= LEN_ZERO;
        end else if (start_s) begin
            words_sent_r <= LEN_ZERO;
        end else if (accept_s && (words_sent_r != LEN_MAX)) begin
            words_sent_r <= words_sent_r + LEN_ONE;
        end
    end

    assign fifo_read  = fifo_read_s;
    assign busy       = busy_s;
    assign done       = done_s;
    assign out_data   = out_data_r;
    assign out_valid  = out_valid_r;
    assign words_sent = words_sent_r;
`ifdef FIFO_RD_PARITY_EN
    assign out_parity = out_parity_r;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomized bench for fifo_burst_reader. The bench plays the FIFO (a queue),
// queues the words each burst must deliver, and a monitor compares every
// downstream transfer against that queue.
`timescale 1ns/1ps
module tb_fifo_burst_reader;

    localparam int DW = 32;
    localparam int LW = 4;

    logic          clock      = 1'b0;
    logic          reset      = 1'b1;
    logic          start      = 1'b0;
    logic [LW-1:0] burst_len  = '0;
    logic          abort      = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data  = '0;
    logic          out_ready  = 1'b0;
    logic          fifo_read;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          busy;
    logic          done;
    logic [LW-1:0] words_sent;
`ifdef FIFO_RD_PARITY_EN
    logic          out_parity;
    logic          prev_par;
`endif

    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] feed_q[$];
    logic [DW-1:0] exp_q[$];
    int            pop_cyc_q[$];
    int            cyc = 0;
    bit            pop_now = 1'b0;
    int            acc_cnt = 0;
    int            done_cnt = 0;
    int            last_acc_cyc = -10;
    int            start_cyc = 0;
    int            cur_len = 0;
    bit            prev_stall = 1'b0;
    bit            prev_done = 1'b0;
    logic [DW-1:0] prev_data = '0;

    fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .burst_len  (burst_len),
        .abort      (abort),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_read  (fifo_read),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
`ifdef FIFO_RD_PARITY_EN
        .out_parity (out_parity),
`endif
        .words_sent (words_sent)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fifo_refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? DW'($urandom()) : fifo_q[0];
    endtask

    function automatic logic drive_ready(input int mode);
        if (mode == 1) return 1'b1;
        if (mode == 2) return ($urandom_range(3, 0) == 0);
        return 1'b1 & $urandom_range(1, 0);
    endfunction

    // FIFO model: apply the pop the monitor saw just before this edge.
    always @(posedge clock) begin
        cyc++;
        #1;
        if (pop_now && reset) begin
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            fifo_refresh();
        end
        pop_now = 1'b0;
    end

    // Monitor: samples settled values mid-cycle and scores every transfer.
    always @(negedge clock) begin
        logic [DW-1:0] e;
        #2;
        if (!reset) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
            pop_now    = 1'b0;
        end else begin
            if (fifo_read) begin
                check("read_while_empty", fifo_empty, 0);
                check("read_during_stall", out_valid && !out_ready, 0);
                pop_now = 1'b1;
                pop_cyc_q.push_back(cyc);
            end
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
`ifdef FIFO_RD_PARITY_EN
                check("hold_parity", out_parity, prev_par);
`endif
            end
            if (out_valid && out_ready && !abort) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no transfer", out_data);
                end else begin
                    tests--;
                    e = exp_q.pop_front();
                    check("out_data", out_data, e);
`ifdef FIFO_RD_PARITY_EN
                    check("out_parity", out_parity, ^e);
`endif
                end
                acc_cnt++;
                last_acc_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                check("done_one_cycle", prev_done, 0);
                if (cur_len == 0) check("done_latency_zero", cyc, start_cyc + 1);
                else              check("done_after_last", cyc, last_acc_cyc + 1);
            end
            prev_done  = done;
            prev_stall = out_valid && !out_ready && !abort;
            prev_data  = out_data;
`ifdef FIFO_RD_PARITY_EN
            prev_par   = out_parity;
`endif
        end
    end

    // One burst: n words, optional abort after abort_at transfers (-1 = none).
    task automatic run_burst(input int n, input int abort_at, input int ready_mode,
                             input bit prefill, input int feed_pct, input bit fixed);
        logic [DW-1:0] w;
        int d0;
        bit got;
        @(negedge clock);
        if ($urandom_range(3, 0) == 0) begin
            abort = 1'b1;
            @(negedge clock);
            abort = 1'b0;
            check("abort_idle_busy", busy, 0);
        end
        feed_q.delete();
        pop_cyc_q.delete();
        for (int i = 0; i < n; i++) begin
            w = fixed ? ((i == 0) ? 32'h0000_0001 : 32'h0000_0003) : DW'($urandom());
            feed_q.push_back(w);
            exp_q.push_back(w);
        end
        if (prefill) while (feed_q.size() > 0) fifo_q.push_back(feed_q.pop_front());
        fifo_refresh();
        acc_cnt   = 0;
        cur_len   = n;
        start_cyc = cyc;
        d0        = done_cnt;
        start     = 1'b1;
        burst_len = LW'(n);
        out_ready = drive_ready(ready_mode);
        got = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clock);
            start = 1'b0;
            if (abort_at < 0 && done_cnt != d0) begin
                got = 1'b1;
            end else if (abort_at >= 0 && acc_cnt == abort_at) begin
                got = 1'b1;
                abort = 1'b1;
                out_ready = 1'b0;
            end else begin
                if (feed_q.size() > 0 && $urandom_range(99, 0) < feed_pct)
                    fifo_q.push_back(feed_q.pop_front());
                fifo_refresh();
                out_ready = drive_ready(ready_mode);
                if ($urandom_range(9, 0) == 0) begin
                    start = 1'b1;
                    burst_len = LW'($urandom());
                end
            end
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL burst_timeout: got no completion, expected burst of %0d to finish", n);
        end
        if (abort_at >= 0) begin
            @(negedge clock);
            abort = 1'b0;
            #2;
            check("abort_busy", busy, 0);
            check("abort_valid", out_valid, 0);
            check("abort_words_sent", words_sent, abort_at);
            repeat (3) @(negedge clock);
            check("abort_no_done", done_cnt, d0);
            fifo_q.delete();
            feed_q.delete();
            exp_q.delete();
            fifo_refresh();
        end else begin
            #2;
            if (n > 0) check("words_sent", words_sent, n);
            check("exp_drained", exp_q.size(), 0);
            check("fifo_drained", fifo_q.size() + feed_q.size(), 0);
            check("done_count", done_cnt - d0, 1);
            check("busy_after_done", busy, 0);
            if (n == 0) check("zero_no_pop", pop_cyc_q.size(), 0);
            if (ready_mode == 1 && prefill && n > 0) begin
                check("pop_count", pop_cyc_q.size(), n);
                if (pop_cyc_q.size() > 0)
                    check("pop_span", pop_cyc_q[pop_cyc_q.size()-1] - pop_cyc_q[0], n - 1);
            end
        end
    endtask

    initial begin
        int n;
        int ab;
        fifo_refresh();
        #2 reset = 1'b0;
        #1;
        check("reset_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_read", fifo_read, 0);
        check("reset_data", out_data, 0);
        check("reset_words", words_sent, 0);
`ifdef FIFO_RD_PARITY_EN
        check("reset_parity", out_parity, 0);
`endif
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        run_burst(4, -1, 1, 1'b1, 100, 1'b0);   // full rate, prefilled
        run_burst(3, -1, 2, 1'b1, 100, 1'b0);   // heavy backpressure
        run_burst(3, -1, 1, 1'b0, 15, 1'b0);    // FIFO runs dry mid-burst
        run_burst(5, 2, 1, 1'b1, 100, 1'b0);    // abort after two words
        run_burst(0, -1, 1, 1'b0, 100, 1'b0);   // zero-length burst
        run_burst(2, -1, 0, 1'b1, 100, 1'b1);   // parity pattern 1, 3
        run_burst(15, -1, 0, 1'b0, 60, 1'b0);   // longest burst

        for (int r = 0; r < 30; r++) begin
            n  = $urandom_range(15, 0);
            ab = (n > 0 && $urandom_range(4, 0) == 0) ? $urandom_range(n - 1, 0) : -1;
            run_burst(n, ab, $urandom_range(2, 0), 1'($urandom_range(1, 0)),
                      $urandom_range(100, 30), 1'b0);
        end

        // Asynchronous reset while a word is held stalled.
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            fifo_q.push_back(DW'($urandom()));
            exp_q.push_back(fifo_q[i]);
        end
        fifo_refresh();
        cur_len   = 3;
        start_cyc = cyc;
        start     = 1'b1;
        burst_len = LW'(3);
        out_ready = 1'b0;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        #2;
        check("rst_pre_valid", out_valid, 1);
        #1 reset = 1'b0;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_read", fifo_read, 0);
        check("rst_words", words_sent, 0);
        check("rst_data", out_data, 0);
        @(negedge clock);
        #2;
        check("rst_hold_valid", out_valid, 0);
        check("rst_hold_read", fifo_read, 0);
        @(negedge clock);
        fifo_q.delete();
        exp_q.delete();
        fifo_refresh();
        reset = 1'b1;

        run_burst(2, -1, 1, 1'b1, 100, 1'b0);   // recovery after reset

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
